alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, port 0 and port 1, for example a main datapath and a branch/address unit.
- Each port has a valid/ready request channel and a valid/ready response channel.
- The block drives the ALU operand and function inputs, captures the ALU result and zero flag into a per-port response register, and arbitrates round-robin.
- Sits between the requesters and the existing ALU module; the ALU itself is instantiated outside this block.

Parameters:
- size, 32, operand and result width; must match the ALU size.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_a  input  size  port 0 operand a
- req0_b  input  size  port 0 operand b
- req0_func  input  3  port 0 ALU function code, encoding identical to ALU func
- req1_valid, req1_ready, req1_a, req1_b, req1_func  same as port 0, for port 1
- rsp0_valid  output  1  port 0 result available
- rsp0_ready  input  1  port 0 consumer takes result
- rsp0_data  output  size  port 0 result
- rsp0_zero  output  1  port 0 zero flag
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_zero  same as port 0, for port 1
- alu_a  output  size  to ALU a
- alu_b  output  size  to ALU b
- alu_func  output  3  to ALU func
- alu_out  input  size  from ALU out
- alu_zero  input  1  from ALU zero_flag

Behaviour:
- Reset (synchronous, sampled at posedge clk while reset=1):
  - rsp0_valid = rsp1_valid = 0; rsp0_data = rsp1_data = 0; rsp0_zero = rsp1_zero = 0.
  - Priority pointer set to port 0.
  - Reset mid-operation discards any buffered results; requests presented in the reset cycle are not accepted, so reqN_ready = 0 while reset=1.
- Per-port slot:
  - Each port has a one-entry response slot; rspN_valid = 1 while the slot is full.
  - The slot is "free" this cycle if rspN_valid = 0, or if rspN_valid = 1 and rspN_ready = 1 (drain and refill in the same cycle is allowed).
- Eligibility: port N is eligible if reqN_valid = 1 and its slot is free.
- Arbitration (combinational, one grant per cycle):
  - Only port 0 eligible → grant 0.
  - Only port 1 eligible → grant 1.
  - Both eligible → grant the port indicated by the priority pointer.
  - Neither eligible → no grant.
- Handshake outputs:
  - reqN_ready = 1 only for the granted port; it may depend combinationally on reqN_valid and rspN_ready.
  - A request transfers when reqN_valid and reqN_ready are both 1.
- ALU drive:
  - alu_a, alu_b, alu_func = granted port's req fields.
  - With no grant, drive the pointer port's fields; these values are don't-care for function but must be stable, with no X.
- Capture: on a transfer at posedge, rspN_data <= alu_out, rspN_zero <= alu_zero, rspN_valid <= 1.
- Response latency: the request accepted in cycle T has its response visible in cycle T+1.
- Drain: rspN_valid && rspN_ready with no new transfer into that slot → rspN_valid <= 0. Data holds its last value.
- Pointer update: after any grant, the pointer moves to the other port. No grant → pointer unchanged.
- Fairness: with both ports continuously eligible, grants alternate 0,1,0,1.
- Backpressure: a port whose slot is full and not draining is never granted; the other port proceeds unaffected.
- Throughput: each port sustains one result per cycle while it is the only eligible port. The total is one ALU operation per cycle.
- Stability: once asserted, rspN_valid and rspN_data must hold until rspN_ready.

Test Plan:
- Reset then idle: assert reset 2 cycles with req0_valid=1 → req0_ready=0 during reset; after reset rsp*_valid=0 and rsp*_data=0.
- Single add: port 0 issues a=5, b=7, func=0, rsp0_ready=1 → accepted cycle T; rsp0_valid=1, rsp0_data=12, rsp0_zero=0 at T+1.
- Simultaneous contention: both ports valid every cycle, port 0 func=1 (9−9), port 1 func=3 (0xF0|0x0F), both rsp_ready=1 → grants alternate 0,1,0,1. Port 0 returns 0 with zero=1; port 1 returns 0xFF with zero=0.
- Backpressure isolation: rsp0_ready=0 with port 0 slot full, both requesting → port 1 granted every cycle. Port 0 is granted the cycle rsp0_ready rises, with same-cycle drain/refill and rsp0_valid staying 1.
- Lui/slt path: port 1 func=6 with b=0x1234 → rsp1_data=0x12340000. Port 1 func=5 with a=3, b=4 → rsp1_data=1.
- Reset mid-operation: both slots full, assert reset one cycle → both rsp_valid=0 next cycle, then port 0 wins the first simultaneous request.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin sharing of one external combinational ALU between two valid/ready ports
module alu_rr_arbiter #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [size-1:0] req0_a,
    input  logic [size-1:0] req0_b,
    input  logic [2:0]      req0_func,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [size-1:0] req1_a,
    input  logic [size-1:0] req1_b,
    input  logic [2:0]      req1_func,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [size-1:0] rsp0_data,
    output logic            rsp0_zero,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [size-1:0] rsp1_data,
    output logic            rsp1_zero,
    output logic [size-1:0] alu_a,
    output logic [size-1:0] alu_b,
    output logic [2:0]      alu_func,
    input  logic [size-1:0] alu_out,
    input  logic            alu_zero
);
    logic            ptr_q, ptr_d;
    logic            v0_q, v0_d, v1_q, v1_d;
    logic [size-1:0] d0_q, d1_q;
    logic            z0_q, z1_q;
    logic            elig0, elig1, gnt0, gnt1, sel;
    always_comb begin
        elig0 = ~reset & req0_valid & (~v0_q | rsp0_ready);
        elig1 = ~reset & req1_valid & (~v1_q | rsp1_ready);
        gnt0  = elig0 & (~elig1 | ~ptr_q);
        gnt1  = elig1 & (~elig0 | ptr_q);
        // idle cycles still present the pointer port's fields so the ALU inputs never float
        sel   = gnt1 | (~gnt0 & ptr_q);
        ptr_d = (gnt0 | gnt1) ? gnt0 : ptr_q;
        v0_d  = gnt0 | (v0_q & ~rsp0_ready);
        v1_d  = gnt1 | (v1_q & ~rsp1_ready);
    end
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign alu_a      = sel ? req1_a : req0_a;
    assign alu_b      = sel ? req1_b : req0_b;
    assign alu_func   = sel ? req1_func : req0_func;
    assign rsp0_valid = v0_q;
    assign rsp0_data  = d0_q;
    assign rsp0_zero  = z0_q;
    assign rsp1_valid = v1_q;
    assign rsp1_data  = d1_q;
    assign rsp1_zero  = z1_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            d0_q  <= '0;
            d1_q  <= '0;
            z0_q  <= 1'b0;
            z1_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            v0_q  <= v0_d;
            v1_q  <= v1_d;
            if (gnt0) begin
                d0_q <= alu_out;
                z0_q <= alu_zero;
            end
            if (gnt1) begin
                d1_q <= alu_out;
                z1_q <= alu_zero;
            end
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed and random checks of alu_rr_arbiter against a slot/pointer reference model
module tb_alu_rr_arbiter;
    logic        clk, reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_func, req1_func, alu_func;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_out;
    logic        alu_zero;
    int          tests, fails;
    logic        m_valid [2];
    logic [31:0] m_data [2];
    logic        m_zero [2];
    int          m_ptr;
    int          last_g;

    alu_rr_arbiter #(.size(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out), .alu_zero(alu_zero)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        case (f)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return {b[15:0], 16'h0};
            default: return ~(a | b);
        endcase
    endfunction

    always_comb begin
        alu_out  = alu_fn(alu_a, alu_b, alu_func);
        alu_zero = (alu_out == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: check handshake/ALU drive before the edge, then advance the model and check responses
    task automatic cyc();
        logic e0, e1;
        int   g;
        #1;
        e0 = !reset && req0_valid && (!m_valid[0] || rsp0_ready);
        e1 = !reset && req1_valid && (!m_valid[1] || rsp1_ready);
        g  = (e0 && e1) ? m_ptr : e0 ? 0 : e1 ? 1 : -1;
        last_g = req1_ready ? 1 : req0_ready ? 0 : -1;
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, g == 0});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, g == 1});
        if (g == 0) chk("alu_a0", alu_a, req0_a);
        if (g == 1) chk("alu_b1", alu_b, req1_b);
        chk("alu_known", {31'd0, $isunknown({alu_a, alu_b, alu_func})}, 32'd0);
        @(posedge clk);
        #1;
        if (reset) begin
            m_ptr = 0;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 1'b0;
                m_data[i]  = '0;
                m_zero[i]  = 1'b0;
            end
        end else begin
            if (g == 0) begin
                m_valid[0] = 1'b1;
                m_data[0]  = alu_fn(req0_a, req0_b, req0_func);
                m_zero[0]  = (m_data[0] == 0);
            end else if (rsp0_ready) m_valid[0] = 1'b0;
            if (g == 1) begin
                m_valid[1] = 1'b1;
                m_data[1]  = alu_fn(req1_a, req1_b, req1_func);
                m_zero[1]  = (m_data[1] == 0);
            end else if (rsp1_ready) m_valid[1] = 1'b0;
            if (g >= 0) m_ptr = 1 - g;
        end
        chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_valid[0]});
        chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_valid[1]});
        chk("rsp0_data", rsp0_data, m_data[0]);
        chk("rsp1_data", rsp1_data, m_data[1]);
        chk("rsp0_zero", {31'd0, rsp0_zero}, {31'd0, m_zero[0]});
        chk("rsp1_zero", {31'd0, rsp1_zero}, {31'd0, m_zero[1]});
        @(negedge clk);
    endtask

    initial begin
        tests = 0; fails = 0; m_ptr = 0; last_g = -1;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_zero[i] = 1'b0;
        end
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_func = 3'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_func = 3'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0; req0_valid = 1'b0;
        chk("idle_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("idle_rsp1_data", rsp1_data, 32'd0);
        // single add
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_func = 3'd0;
        cyc();
        chk("add_data", rsp0_data, 32'd12);
        chk("add_zero", {31'd0, rsp0_zero}, 32'd0);
        // contention: expect alternation
        req0_a = 32'd9; req0_b = 32'd9; req0_func = 3'd1;
        req1_valid = 1'b1; req1_a = 32'h0F0; req1_b = 32'h00F; req1_func = 3'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("alt_grant", last_g, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("sub_zero_data", rsp0_data, 32'd0);
        chk("sub_zero_flag", {31'd0, rsp0_zero}, 32'd1);
        chk("or_data", rsp1_data, 32'hFF);
        chk("or_zero", {31'd0, rsp1_zero}, 32'd0);
        // backpressure on port 0
        rsp0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_grant1", last_g, 32'd1);
        end
        rsp0_ready = 1'b1;
        cyc();
        chk("bp_refill_grant0", last_g, 32'd0);
        chk("bp_refill_valid", {31'd0, rsp0_valid}, 32'd1);
        // lui and slt on port 1
        req0_valid = 1'b0;
        req1_func = 3'd6; req1_b = 32'h1234; req1_a = 32'd0;
        cyc();
        chk("lui", rsp1_data, 32'h12340000);
        req1_func = 3'd5; req1_a = 32'd3; req1_b = 32'd4;
        cyc();
        chk("slt", rsp1_data, 32'd1);
        // reset with both slots full
        req0_valid = 1'b1; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        cyc(); cyc();
        chk("full0", {31'd0, rsp0_valid}, 32'd1);
        chk("full1", {31'd0, rsp1_valid}, 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_reset_v0", {31'd0, rsp0_valid}, 32'd0);
        chk("mid_reset_v1", {31'd0, rsp1_valid}, 32'd0);
        cyc();
        chk("post_reset_grant0", last_g, 32'd0);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            req0_valid = $urandom_range(0, 3) != 0;
            req1_valid = $urandom_range(0, 3) != 0;
            rsp0_ready = $urandom_range(0, 2) != 0;
            rsp1_ready = $urandom_range(0, 2) != 0;
            req0_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            req0_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            req1_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            req1_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 7));
            req0_func = 3'($urandom_range(0, 7));
            req1_func = 3'($urandom_range(0, 7));
            cyc();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
